// File: rtl/tex_agent.sv
// tex_agent: core-side texture request initiator with an out-of-order pending table.
// Optional perf counters are enabled by defining TEX_AGENT_PERF_EN.
module tex_agent #(
  parameter  int NUM_LANES    = 4,
  parameter  int NUM_WARPS    = 4,
  parameter  int PENDING_SIZE = 8,
  parameter  int UUID_WIDTH   = 44,
  parameter  int PC_WIDTH     = 32,
  parameter  int RD_BITS      = 5,
  parameter  int LOD_BITS     = 4,
  parameter  int STAGE_BITS   = 1,
  localparam int WID_W        = ($clog2(NUM_WARPS) > 0) ? $clog2(NUM_WARPS) : 1,
  localparam int IDX_W        = $clog2(PENDING_SIZE),
  localparam int TAG_WIDTH    = UUID_WIDTH + IDX_W
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          exe_valid,
  input  logic [UUID_WIDTH-1:0]         exe_uuid,
  input  logic [WID_W-1:0]              exe_wid,
  input  logic [NUM_LANES-1:0]          exe_tmask,
  input  logic [PC_WIDTH-1:0]           exe_pc,
  input  logic [RD_BITS-1:0]            exe_rd,
  input  logic [2*NUM_LANES*32-1:0]     exe_coords,
  input  logic [NUM_LANES*LOD_BITS-1:0] exe_lod,
  input  logic [STAGE_BITS-1:0]         exe_stage,
  output logic                          exe_ready,
  output logic                          tex_req_valid,
  output logic [NUM_LANES-1:0]          tex_req_mask,
  output logic [2*NUM_LANES*32-1:0]     tex_req_coords,
  output logic [NUM_LANES*LOD_BITS-1:0] tex_req_lod,
  output logic [STAGE_BITS-1:0]         tex_req_stage,
  output logic [TAG_WIDTH-1:0]          tex_req_tag,
  input  logic                          tex_req_ready,
  input  logic                          tex_rsp_valid,
  input  logic [NUM_LANES*32-1:0]       tex_rsp_texels,
  input  logic [TAG_WIDTH-1:0]          tex_rsp_tag,
  output logic                          tex_rsp_ready,
  output logic                          commit_valid,
  output logic [UUID_WIDTH-1:0]         commit_uuid,
  output logic [WID_W-1:0]              commit_wid,
  output logic [NUM_LANES-1:0]          commit_tmask,
  output logic [PC_WIDTH-1:0]           commit_pc,
  output logic [RD_BITS-1:0]            commit_rd,
  output logic [NUM_LANES*32-1:0]       commit_data,
  input  logic                          commit_ready
`ifdef TEX_AGENT_PERF_EN
  ,
  output logic [43:0]                   perf_stall_cycles,
  output logic [43:0]                   perf_pending_sum
`endif
);

  function automatic logic [IDX_W-1:0] lowest_free(input logic [PENDING_SIZE-1:0] mask);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = PENDING_SIZE - 1; i >= 0; i--) begin
      idx = mask[i] ? IDX_W'(i) : idx;
    end
    return idx;
  endfunction

  logic [PENDING_SIZE-1:0] free_q, free_d, alloc_oh_s, release_oh_s;
  logic [IDX_W:0]          count_q, count_d;
  logic                    full_s, exe_fire_s, rsp_fire_s;
  logic [IDX_W-1:0]        alloc_idx_s, rsp_idx_s;

  logic [UUID_WIDTH-1:0] tbl_uuid_q  [PENDING_SIZE];
  logic [UUID_WIDTH-1:0] tbl_uuid_d  [PENDING_SIZE];
  logic [WID_W-1:0]      tbl_wid_q   [PENDING_SIZE];
  logic [WID_W-1:0]      tbl_wid_d   [PENDING_SIZE];
  logic [NUM_LANES-1:0]  tbl_tmask_q [PENDING_SIZE];
  logic [NUM_LANES-1:0]  tbl_tmask_d [PENDING_SIZE];
  logic [PC_WIDTH-1:0]   tbl_pc_q    [PENDING_SIZE];
  logic [PC_WIDTH-1:0]   tbl_pc_d    [PENDING_SIZE];
  logic [RD_BITS-1:0]    tbl_rd_q    [PENDING_SIZE];
  logic [RD_BITS-1:0]    tbl_rd_d    [PENDING_SIZE];

  logic                          req_valid_q, req_valid_d;
  logic [NUM_LANES-1:0]          req_mask_q, req_mask_d;
  logic [2*NUM_LANES*32-1:0]     req_coords_q, req_coords_d;
  logic [NUM_LANES*LOD_BITS-1:0] req_lod_q, req_lod_d;
  logic [STAGE_BITS-1:0]         req_stage_q, req_stage_d;
  logic [TAG_WIDTH-1:0]          req_tag_q, req_tag_d;

  logic                    cm_valid_q, cm_valid_d;
  logic [UUID_WIDTH-1:0]   cm_uuid_q, cm_uuid_d;
  logic [WID_W-1:0]        cm_wid_q, cm_wid_d;
  logic [NUM_LANES-1:0]    cm_tmask_q, cm_tmask_d;
  logic [PC_WIDTH-1:0]     cm_pc_q, cm_pc_d;
  logic [RD_BITS-1:0]      cm_rd_q, cm_rd_d;
  logic [NUM_LANES*32-1:0] cm_data_q, cm_data_d;

  // Full is taken from registered state so a same-cycle release cannot raise exe_ready.
  assign full_s        = ~|free_q;
  assign alloc_idx_s   = lowest_free(free_q);
  assign rsp_idx_s     = tex_rsp_tag[IDX_W-1:0];
  assign exe_ready     = !full_s && (!req_valid_q || tex_req_ready);
  assign tex_rsp_ready = !cm_valid_q || commit_ready;
  assign exe_fire_s    = exe_valid && exe_ready;
  assign rsp_fire_s    = tex_rsp_valid && tex_rsp_ready;

  // Free mask and occupancy update; alloc and release never hit the same slot.
  always_comb begin
    alloc_oh_s   = exe_fire_s ? (PENDING_SIZE'(1) << alloc_idx_s) : '0;
    release_oh_s = rsp_fire_s ? (PENDING_SIZE'(1) << rsp_idx_s) : '0;
    free_d       = (free_q & ~alloc_oh_s) | release_oh_s;
    count_d      = count_q + (IDX_W + 1)'(exe_fire_s) - (IDX_W + 1)'(rsp_fire_s);
  end

  // Pending-table write of the warp context on instruction accept.
  always_comb begin
    tbl_uuid_d  = tbl_uuid_q;
    tbl_wid_d   = tbl_wid_q;
    tbl_tmask_d = tbl_tmask_q;
    tbl_pc_d    = tbl_pc_q;
    tbl_rd_d    = tbl_rd_q;
    if (exe_fire_s) begin
      tbl_uuid_d[alloc_idx_s]  = exe_uuid;
      tbl_wid_d[alloc_idx_s]   = exe_wid;
      tbl_tmask_d[alloc_idx_s] = exe_tmask;
      tbl_pc_d[alloc_idx_s]    = exe_pc;
      tbl_rd_d[alloc_idx_s]    = exe_rd;
    end else begin
      tbl_uuid_d[alloc_idx_s]  = tbl_uuid_q[alloc_idx_s];
    end
  end

  // Request output register; loads only when empty or draining this cycle.
  always_comb begin
    req_valid_d = exe_fire_s ? 1'b1 : (req_valid_q && !tex_req_ready);
    if (exe_fire_s) begin
      req_mask_d   = exe_tmask;
      req_coords_d = exe_coords;
      req_lod_d    = exe_lod;
      req_stage_d  = exe_stage;
      req_tag_d    = {exe_uuid, alloc_idx_s};
    end else begin
      req_mask_d   = req_mask_q;
      req_coords_d = req_coords_q;
      req_lod_d    = req_lod_q;
      req_stage_d  = req_stage_q;
      req_tag_d    = req_tag_q;
    end
  end

  // Commit register; context comes from the slot named by the echoed tag.
  always_comb begin
    cm_valid_d = rsp_fire_s ? 1'b1 : (cm_valid_q && !commit_ready);
    if (rsp_fire_s) begin
      cm_uuid_d  = tbl_uuid_q[rsp_idx_s];
      cm_wid_d   = tbl_wid_q[rsp_idx_s];
      cm_tmask_d = tbl_tmask_q[rsp_idx_s];
      cm_pc_d    = tbl_pc_q[rsp_idx_s];
      cm_rd_d    = tbl_rd_q[rsp_idx_s];
      cm_data_d  = tex_rsp_texels;
    end else begin
      cm_uuid_d  = cm_uuid_q;
      cm_wid_d   = cm_wid_q;
      cm_tmask_d = cm_tmask_q;
      cm_pc_d    = cm_pc_q;
      cm_rd_d    = cm_rd_q;
      cm_data_d  = cm_data_q;
    end
  end

  // Control state with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      free_q      <= '1;
      count_q     <= '0;
      req_valid_q <= 1'b0;
      cm_valid_q  <= 1'b0;
    end else begin
      free_q      <= free_d;
      count_q     <= count_d;
      req_valid_q <= req_valid_d;
      cm_valid_q  <= cm_valid_d;
    end
  end

  // Payload state; only meaningful while the matching valid/busy bit is set.
  always_ff @(posedge clk) begin
    tbl_uuid_q   <= tbl_uuid_d;
    tbl_wid_q    <= tbl_wid_d;
    tbl_tmask_q  <= tbl_tmask_d;
    tbl_pc_q     <= tbl_pc_d;
    tbl_rd_q     <= tbl_rd_d;
    req_mask_q   <= req_mask_d;
    req_coords_q <= req_coords_d;
    req_lod_q    <= req_lod_d;
    req_stage_q  <= req_stage_d;
    req_tag_q    <= req_tag_d;
    cm_uuid_q    <= cm_uuid_d;
    cm_wid_q     <= cm_wid_d;
    cm_tmask_q   <= cm_tmask_d;
    cm_pc_q      <= cm_pc_d;
    cm_rd_q      <= cm_rd_d;
    cm_data_q    <= cm_data_d;
  end

  assign tex_req_valid  = req_valid_q;
  assign tex_req_mask   = req_mask_q;
  assign tex_req_coords = req_coords_q;
  assign tex_req_lod    = req_lod_q;
  assign tex_req_stage  = req_stage_q;
  assign tex_req_tag    = req_tag_q;
  assign commit_valid   = cm_valid_q;
  assign commit_uuid    = cm_uuid_q;
  assign commit_wid     = cm_wid_q;
  assign commit_tmask   = cm_tmask_q;
  assign commit_pc      = cm_pc_q;
  assign commit_rd      = cm_rd_q;
  assign commit_data    = cm_data_q;

`ifdef TEX_AGENT_PERF_EN
  logic [43:0] stall_q, stall_d, psum_q, psum_d;

  // Perf counters wrap naturally at 2^44.
  always_comb begin
    stall_d = stall_q + 44'(exe_valid && !exe_ready);
    psum_d  = psum_q + 44'(count_q);
  end

  // Perf counter state.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= 44'd0;
      psum_q  <= 44'd0;
    end else begin
      stall_q <= stall_d;
      psum_q  <= psum_d;
    end
  end

  assign perf_stall_cycles = stall_q;
  assign perf_pending_sum  = psum_q;
`endif

  tex_agent_checker #(
    .PENDING_SIZE (PENDING_SIZE),
    .IDX_W        (IDX_W),
    .UUID_WIDTH   (UUID_WIDTH)
  ) u_checker (
    .clk           (clk),
    .reset         (reset),
    .rsp_fire      (rsp_fire_s),
    .rsp_slot_free (free_q[rsp_idx_s]),
    .rsp_uuid      (tex_rsp_tag[TAG_WIDTH-1:IDX_W]),
    .slot_uuid     (tbl_uuid_q[rsp_idx_s]),
    .count         (count_q)
  );

endmodule

// Protocol checks: responses must target an allocated slot and echo its uuid.
module tex_agent_checker #(
  parameter int PENDING_SIZE = 8,
  parameter int IDX_W        = 3,
  parameter int UUID_WIDTH   = 44
) (
  input logic                  clk,
  input logic                  reset,
  input logic                  rsp_fire,
  input logic                  rsp_slot_free,
  input logic [UUID_WIDTH-1:0] rsp_uuid,
  input logic [UUID_WIDTH-1:0] slot_uuid,
  input logic [IDX_W:0]        count
);
  a_rsp_slot_busy: assert property (@(posedge clk) disable iff (reset) rsp_fire |-> !rsp_slot_free);
  a_rsp_uuid_match: assert property (@(posedge clk) disable iff (reset) rsp_fire |-> (rsp_uuid == slot_uuid));
  a_count_bound: assert property (@(posedge clk) disable iff (reset) count <= (IDX_W + 1)'(PENDING_SIZE));
endmodule

// File: tb/tb_tex_agent.sv
// Self-checking bench for tex_agent: directed scenarios plus a randomized run
// against a transaction-level model of the pending table.
module tb_tex_agent;
  localparam int NL = 4, UW = 44, PW = 32, RB = 5, IDX = 3, PS = 8, WW = 2;
  localparam int TW = UW + IDX;
  localparam int CMW = UW + WW + NL + PW + RB + NL * 32;
  localparam int RQW = TW + NL + 2 * NL * 32 + NL * 4 + 1;

  logic clk = 1'b0;
  logic reset;
  logic exe_valid, exe_ready, tex_req_valid, tex_req_ready, tex_rsp_valid, tex_rsp_ready;
  logic commit_valid, commit_ready;
  logic [UW-1:0] exe_uuid, commit_uuid;
  logic [WW-1:0] exe_wid, commit_wid;
  logic [NL-1:0] exe_tmask, tex_req_mask, commit_tmask;
  logic [PW-1:0] exe_pc, commit_pc;
  logic [RB-1:0] exe_rd, commit_rd;
  logic [2*NL*32-1:0] exe_coords, tex_req_coords;
  logic [NL*4-1:0] exe_lod, tex_req_lod;
  logic [0:0] exe_stage, tex_req_stage;
  logic [TW-1:0] tex_req_tag, tex_rsp_tag;
  logic [NL*32-1:0] tex_rsp_texels, commit_data;
`ifdef TEX_AGENT_PERF_EN
  logic [43:0] perf_stall_cycles, perf_pending_sum;
`endif

  always #5 clk = ~clk;

  tex_agent dut (
    .clk(clk), .reset(reset),
    .exe_valid(exe_valid), .exe_uuid(exe_uuid), .exe_wid(exe_wid), .exe_tmask(exe_tmask),
    .exe_pc(exe_pc), .exe_rd(exe_rd), .exe_coords(exe_coords), .exe_lod(exe_lod),
    .exe_stage(exe_stage), .exe_ready(exe_ready),
    .tex_req_valid(tex_req_valid), .tex_req_mask(tex_req_mask), .tex_req_coords(tex_req_coords),
    .tex_req_lod(tex_req_lod), .tex_req_stage(tex_req_stage), .tex_req_tag(tex_req_tag),
    .tex_req_ready(tex_req_ready),
    .tex_rsp_valid(tex_rsp_valid), .tex_rsp_texels(tex_rsp_texels), .tex_rsp_tag(tex_rsp_tag),
    .tex_rsp_ready(tex_rsp_ready),
    .commit_valid(commit_valid), .commit_uuid(commit_uuid), .commit_wid(commit_wid),
    .commit_tmask(commit_tmask), .commit_pc(commit_pc), .commit_rd(commit_rd),
    .commit_data(commit_data),
`ifdef TEX_AGENT_PERF_EN
    .perf_stall_cycles(perf_stall_cycles), .perf_pending_sum(perf_pending_sum),
`endif
    .commit_ready(commit_ready)
  );

  int pass_cnt = 0;
  int total_cnt = 0;

  // Transaction-level model: which slots hold which instruction context.
  logic          m_busy  [PS];
  logic [UW-1:0] m_uuid  [PS];
  logic [WW-1:0] m_wid   [PS];
  logic [NL-1:0] m_tmask [PS];
  logic [PW-1:0] m_pc    [PS];
  logic [RB-1:0] m_rd    [PS];
  int            inflight[$];

  function automatic int model_free_slot();
    for (int i = 0; i < PS; i++) if (!m_busy[i]) return i;
    return -1;
  endfunction

  function automatic logic [NL*32-1:0] texels_of(input int base);
    logic [NL*32-1:0] t;
    for (int l = 0; l < NL; l++) t[l*32 +: 32] = 32'(base + l);
    return t;
  endfunction

  task automatic idle_inputs();
    exe_valid = 1'b0; exe_uuid = '0; exe_wid = '0; exe_tmask = '0; exe_pc = '0; exe_rd = '0;
    exe_coords = '0; exe_lod = '0; exe_stage = '0;
    tex_rsp_valid = 1'b0; tex_rsp_texels = '0; tex_rsp_tag = '0;
    tex_req_ready = 1'b1; commit_ready = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < PS; i++) m_busy[i] = 1'b0;
    inflight.delete();
  endtask

  task automatic drive_exe(input logic [UW-1:0] u, input logic [WW-1:0] w, input logic [NL-1:0] m,
                           input logic [PW-1:0] pc, input logic [RB-1:0] rd);
    exe_valid = 1'b1; exe_uuid = u; exe_wid = w; exe_tmask = m; exe_pc = pc; exe_rd = rd;
    exe_coords = {8{u[31:0]}}; exe_lod = 16'h1234; exe_stage = 1'b0;
  endtask

  task automatic drive_rsp(input logic [UW-1:0] u, input int slot, input logic [NL*32-1:0] tx);
    tex_rsp_valid = 1'b1; tex_rsp_tag = {u, 3'(slot)}; tex_rsp_texels = tx;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    total_cnt++; if (tex_req_valid !== 1'b0) $display("FAIL reset_req_valid got %0b exp 0", tex_req_valid); else pass_cnt++;
    total_cnt++; if (commit_valid !== 1'b0) $display("FAIL reset_commit_valid got %0b exp 0", commit_valid); else pass_cnt++;
    total_cnt++; if (exe_ready !== 1'b1) $display("FAIL reset_exe_ready got %0b exp 1", exe_ready); else pass_cnt++;
    total_cnt++; if (tex_rsp_ready !== 1'b1) $display("FAIL reset_rsp_ready got %0b exp 1", tex_rsp_ready); else pass_cnt++;
  endtask

  task automatic test_single();
    do_reset();
    drive_exe(44'd5, 2'd1, 4'b1011, 32'h0000_1000, 5'd3);
    @(negedge clk);
    exe_valid = 1'b0;
    total_cnt++; if (tex_req_valid !== 1'b1) $display("FAIL single_req_valid got %0b exp 1", tex_req_valid); else pass_cnt++;
    total_cnt++; if ({tex_req_tag, tex_req_mask} !== {44'd5, 3'd0, 4'b1011})
      $display("FAIL single_req_tag got %h/%b exp %h/1011", tex_req_tag, tex_req_mask, {44'd5, 3'd0}); else pass_cnt++;
    repeat (2) @(negedge clk);
    drive_rsp(44'd5, 0, texels_of(1));
    @(negedge clk);
    tex_rsp_valid = 1'b0;
    total_cnt++; if (commit_valid !== 1'b1) $display("FAIL single_commit_valid got %0b exp 1", commit_valid); else pass_cnt++;
    total_cnt++; if ({commit_uuid, commit_wid, commit_rd, commit_tmask, commit_pc, commit_data} !==
                     {44'd5, 2'd1, 5'd3, 4'b1011, 32'h0000_1000, 32'd4, 32'd3, 32'd2, 32'd1})
      $display("FAIL single_commit_fields got uuid=%0d wid=%0d rd=%0d tmask=%b data=%h", commit_uuid, commit_wid, commit_rd, commit_tmask, commit_data);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (commit_valid !== 1'b0) $display("FAIL single_commit_drain got %0b exp 0", commit_valid); else pass_cnt++;
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 0; i < PS; i++) begin
      drive_exe(44'(100 + i), 2'(i), 4'hF, 32'(i * 4), 5'(i));
      #1;
      total_cnt++; if (exe_ready !== 1'b1) $display("FAIL fill_ready[%0d] got %0b exp 1", i, exe_ready); else pass_cnt++;
      @(negedge clk);
      total_cnt++; if (tex_req_tag !== {44'(100 + i), 3'(i)})
        $display("FAIL fill_tag[%0d] got %h exp %h", i, tex_req_tag, {44'(100 + i), 3'(i)}); else pass_cnt++;
    end
    drive_exe(44'd200, 2'd0, 4'h3, 32'h44, 5'd9);
    #1;
    total_cnt++; if (exe_ready !== 1'b0) $display("FAIL full_ready got %0b exp 0", exe_ready); else pass_cnt++;
    @(negedge clk);
    drive_rsp(44'd102, 2, texels_of(50));
    #1;
    total_cnt++; if (exe_ready !== 1'b0) $display("FAIL full_same_cycle_free got %0b exp 0", exe_ready); else pass_cnt++;
    @(negedge clk);
    tex_rsp_valid = 1'b0;
    #1;
    total_cnt++; if (exe_ready !== 1'b1) $display("FAIL full_ready_after_free got %0b exp 1", exe_ready); else pass_cnt++;
    total_cnt++; if ({commit_valid, commit_uuid} !== {1'b1, 44'd102})
      $display("FAIL full_commit got v=%0b uuid=%0d exp v=1 uuid=102", commit_valid, commit_uuid); else pass_cnt++;
    @(negedge clk);
    exe_valid = 1'b0;
    total_cnt++; if (tex_req_tag !== {44'd200, 3'd2}) $display("FAIL refill_tag got %h exp %h", tex_req_tag, {44'd200, 3'd2}); else pass_cnt++;
  endtask

  task automatic test_out_of_order();
    int order[3] = '{2, 0, 1};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive_exe(44'(10 + i), 2'(i), 4'(i + 1), 32'(32'h2000 + i * 16), 5'(7 + i));
      @(negedge clk);
    end
    exe_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      int s = order[k];
      drive_rsp(44'(10 + s), s, texels_of(1000 * (s + 1)));
      @(negedge clk);
      total_cnt++; if ({commit_valid, commit_uuid, commit_wid, commit_tmask, commit_pc, commit_rd, commit_data} !==
                       {1'b1, 44'(10 + s), 2'(s), 4'(s + 1), 32'(32'h2000 + s * 16), 5'(7 + s), texels_of(1000 * (s + 1))})
        $display("FAIL ooo_commit[%0d] got v=%0b uuid=%0d pc=%h rd=%0d exp uuid=%0d", k, commit_valid, commit_uuid, commit_pc, commit_rd, 10 + s);
      else pass_cnt++;
    end
    tex_rsp_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    do_reset();
    commit_ready = 1'b0;
    drive_exe(44'd30, 2'd2, 4'hF, 32'h300, 5'd1); @(negedge clk);
    drive_exe(44'd31, 2'd3, 4'h0, 32'h310, 5'd2); @(negedge clk);
    exe_valid = 1'b0;
    drive_rsp(44'd30, 0, texels_of(300));
    @(negedge clk);
    drive_rsp(44'd31, 1, texels_of(310));
    for (int c = 0; c < 4; c++) begin
      #1;
      total_cnt++; if ({tex_rsp_ready, commit_valid, commit_uuid, commit_data} !== {1'b0, 1'b1, 44'd30, texels_of(300)})
        $display("FAIL cm_stall[%0d] got rdy=%0b v=%0b uuid=%0d exp rdy=0 v=1 uuid=30", c, tex_rsp_ready, commit_valid, commit_uuid);
      else pass_cnt++;
      @(negedge clk);
    end
    commit_ready = 1'b1;
    @(negedge clk);
    tex_rsp_valid = 1'b0;
    total_cnt++; if ({commit_valid, commit_uuid, commit_tmask} !== {1'b1, 44'd31, 4'h0})
      $display("FAIL cm_release got v=%0b uuid=%0d tmask=%b exp v=1 uuid=31 tmask=0000", commit_valid, commit_uuid, commit_tmask); else pass_cnt++;
    tex_req_ready = 1'b0;
    drive_exe(44'd40, 2'd0, 4'h5, 32'h400, 5'd4);
    @(negedge clk);
    drive_exe(44'd41, 2'd1, 4'h6, 32'h410, 5'd5);
    for (int c = 0; c < 4; c++) begin
      #1;
      total_cnt++; if ({exe_ready, tex_req_valid, tex_req_tag, tex_req_mask} !== {1'b0, 1'b1, 44'd40, 3'd0, 4'h5})
        $display("FAIL req_stall[%0d] got rdy=%0b v=%0b tag=%h", c, exe_ready, tex_req_valid, tex_req_tag);
      else pass_cnt++;
      @(negedge clk);
    end
    tex_req_ready = 1'b1;
    @(negedge clk);
    exe_valid = 1'b0;
    total_cnt++; if (tex_req_tag !== {44'd41, 3'd1}) $display("FAIL req_release got %h exp %h", tex_req_tag, {44'd41, 3'd1}); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    commit_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_exe(44'(60 + i), 2'(i), 4'hF, 32'(i), 5'(i)); @(negedge clk);
    end
    exe_valid = 1'b0;
    drive_rsp(44'd60, 0, texels_of(60));
    @(negedge clk);
    tex_rsp_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    commit_ready = 1'b1;
    #1;
    total_cnt++; if ({tex_req_valid, commit_valid} !== 2'b00)
      $display("FAIL midreset_valids got req=%0b cm=%0b exp 0/0", tex_req_valid, commit_valid); else pass_cnt++;
    drive_exe(44'd77, 2'd1, 4'h1, 32'h77, 5'd7);
    @(negedge clk);
    exe_valid = 1'b0;
    total_cnt++; if (tex_req_tag !== {44'd77, 3'd0}) $display("FAIL midreset_slot got %h exp %h", tex_req_tag, {44'd77, 3'd0}); else pass_cnt++;
  endtask

  task automatic test_random();
    logic m_req_v, m_cm_v, full, x_exe_rdy, x_rsp_rdy, exe_f, rsp_f;
    logic [RQW-1:0] m_req_vec;
    logic [CMW-1:0] m_cm_vec;
    int m_req_slot, pick, s, a;
    do_reset();
    m_req_v = 1'b0; m_cm_v = 1'b0; m_req_vec = '0; m_cm_vec = '0; m_req_slot = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      exe_valid = ($urandom_range(0, 99) < 60);
      exe_uuid = 44'({$urandom(), $urandom()});
      exe_wid = 2'($urandom()); exe_tmask = 4'($urandom()); exe_pc = $urandom(); exe_rd = 5'($urandom());
      for (int w = 0; w < 8; w++) exe_coords[w*32 +: 32] = $urandom();
      exe_lod = 16'($urandom()); exe_stage = 1'($urandom());
      tex_req_ready = ($urandom_range(0, 99) < 70);
      commit_ready = ($urandom_range(0, 99) < 70);
      pick = -1; s = 0;
      if (inflight.size() > 0 && $urandom_range(0, 99) < 50) begin
        pick = $urandom_range(0, inflight.size() - 1);
        s = inflight[pick];
        drive_rsp(m_uuid[s], s, {$urandom(), $urandom(), $urandom(), $urandom()});
      end else begin
        tex_rsp_valid = 1'b0;
      end
      #1;
      full = 1'b1;
      for (int i = 0; i < PS; i++) if (!m_busy[i]) full = 1'b0;
      x_exe_rdy = !full && (!m_req_v || tex_req_ready);
      x_rsp_rdy = !m_cm_v || commit_ready;
      total_cnt++; if ({exe_ready, tex_rsp_ready} !== {x_exe_rdy, x_rsp_rdy})
        $display("FAIL rnd_ready[%0d] got exe=%0b rsp=%0b exp exe=%0b rsp=%0b", cyc, exe_ready, tex_rsp_ready, x_exe_rdy, x_rsp_rdy); else pass_cnt++;
      total_cnt++; if (tex_req_valid !== m_req_v || (m_req_v && {tex_req_tag, tex_req_mask, tex_req_coords, tex_req_lod, tex_req_stage} !== m_req_vec))
        $display("FAIL rnd_req[%0d] got v=%0b tag=%h exp v=%0b tag=%h", cyc, tex_req_valid, tex_req_tag, m_req_v, m_req_vec[RQW-1 -: TW]); else pass_cnt++;
      total_cnt++; if (commit_valid !== m_cm_v || (m_cm_v && {commit_uuid, commit_wid, commit_tmask, commit_pc, commit_rd, commit_data} !== m_cm_vec))
        $display("FAIL rnd_commit[%0d] got v=%0b uuid=%h exp v=%0b uuid=%h", cyc, commit_valid, commit_uuid, m_cm_v, m_cm_vec[CMW-1 -: UW]); else pass_cnt++;
      exe_f = exe_valid && x_exe_rdy;
      rsp_f = tex_rsp_valid && x_rsp_rdy;
      a = model_free_slot();
      if (m_req_v && tex_req_ready) begin inflight.push_back(m_req_slot); m_req_v = 1'b0; end
      if (m_cm_v && commit_ready) m_cm_v = 1'b0;
      if (exe_f) begin
        m_busy[a] = 1'b1; m_uuid[a] = exe_uuid; m_wid[a] = exe_wid; m_tmask[a] = exe_tmask; m_pc[a] = exe_pc; m_rd[a] = exe_rd;
        m_req_v = 1'b1; m_req_slot = a;
        m_req_vec = {exe_uuid, 3'(a), exe_tmask, exe_coords, exe_lod, exe_stage};
      end
      if (rsp_f) begin
        m_busy[s] = 1'b0; m_cm_v = 1'b1;
        m_cm_vec = {m_uuid[s], m_wid[s], m_tmask[s], m_pc[s], m_rd[s], tex_rsp_texels};
        inflight.delete(pick);
      end
      @(negedge clk);
    end
    idle_inputs();
  endtask

`ifdef TEX_AGENT_PERF_EN
  task automatic test_perf();
    do_reset();
    for (int i = 0; i < PS; i++) begin
      drive_exe(44'(500 + i), 2'd0, 4'hF, 32'd0, 5'd0); @(negedge clk);
    end
    drive_exe(44'd600, 2'd0, 4'hF, 32'd0, 5'd0);
    repeat (5) @(negedge clk);
    exe_valid = 1'b0;
    #1;
    total_cnt++; if (perf_stall_cycles !== 44'd5) $display("FAIL perf_stall got %0d exp 5", perf_stall_cycles); else pass_cnt++;
    total_cnt++; if (perf_pending_sum !== 44'd68) $display("FAIL perf_pending_sum got %0d exp 68", perf_pending_sum); else pass_cnt++;
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_single();
    test_fill();
    test_out_of_order();
    test_backpressure();
    test_reset_mid();
    test_random();
`ifdef TEX_AGENT_PERF_EN
    test_perf();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
